// File: rtl/simmem_pkg.sv
// Shared defaults and types for the simulated-memory message store.
// Optional feature macro: SIMMEM_STORE_OCCUPANCY_EN (adds occupancy_o on the store).
package simmem_pkg;

  localparam int StructWidth = 64;
  localparam int IDWidth     = 4;
  localparam int TotCapacity = 16;

  localparam int PtrWidth     = $clog2(TotCapacity);
  localparam int PayloadWidth = StructWidth - IDWidth;

  typedef logic [PtrWidth-1:0]     slot_ptr_t;
  typedef logic [IDWidth-1:0]      id_t;
  typedef logic [PayloadWidth-1:0] payload_t;

endpackage

// File: rtl/simmem_message_linkedlist_store_if.sv
// Upstream push handshake, per-ID head outputs and release port of the store.
// Push handshake: a message transfers on a rising edge where in_valid_i and in_ready_o are both high.
interface simmem_message_linkedlist_store_if #(
  parameter int StructWidth = 64,
  parameter int IDWidth     = 4
);

  localparam int NumIds       = 2 ** IDWidth;
  localparam int PayloadWidth = StructWidth - IDWidth;

  logic [StructWidth-1:0]                in_data_i;
  logic                                  in_valid_i;
  logic                                  in_ready_o;
  logic [NumIds-1:0][PayloadWidth-1:0]   buf_data_o;
  logic [NumIds-1:0]                     buf_data_valid_o;
  logic [NumIds-1:0]                     release_onehot_i;

  modport slave (
    input  in_data_i, in_valid_i, release_onehot_i,
    output in_ready_o, buf_data_o, buf_data_valid_o
  );

  modport master (
    output in_data_i, in_valid_i, release_onehot_i,
    input  in_ready_o, buf_data_o, buf_data_valid_o
  );

endinterface

// File: rtl/simmem_message_linkedlist_store_freelist.sv
// Free-slot tracker: registered free-bit vector, lowest-index-first allocation.
// A released slot only becomes visible to allocation on the following cycle.
module simmem_freelist #(
  parameter int TotCapacity = 16,
  localparam int PtrWidth   = $clog2(TotCapacity)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_i,
  output logic [PtrWidth-1:0] alloc_ptr_o,
  output logic                free_any_o,
  input  logic                release_i,
  input  logic [PtrWidth-1:0] release_ptr_i
);

  logic [TotCapacity-1:0] free_q;

  always_comb begin
    alloc_ptr_o = '0;
    for (int i = TotCapacity - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_ptr_o = PtrWidth'(i);
    end
  end

  assign free_any_o = |free_q;

  // Allocated and released slots are always distinct, so the order of these updates is irrelevant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_q <= '1;
    end else begin
      if (alloc_i)   free_q[alloc_ptr_o]   <= 1'b0;
      if (release_i) free_q[release_ptr_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/simmem_message_linkedlist_store.sv
// Per-ID FIFO message store built as linked lists over a shared slot RAM.
// Optional macro SIMMEM_STORE_OCCUPANCY_EN adds the occupancy_o counter output.
module simmem_message_linkedlist_store #(
  parameter int StructWidth = simmem_pkg::StructWidth,
  parameter int IDWidth     = simmem_pkg::IDWidth,
  parameter int TotCapacity = simmem_pkg::TotCapacity
) (
  input  logic clk_i,
  input  logic rst_i,
  simmem_message_linkedlist_store_if.slave bus
`ifdef SIMMEM_STORE_OCCUPANCY_EN
  ,
  output logic [$clog2(TotCapacity+1)-1:0] occupancy_o
`endif
);

  localparam int NumIds       = 2 ** IDWidth;
  localparam int PayloadWidth = StructWidth - IDWidth;
  localparam int PtrWidth     = $clog2(TotCapacity);

  typedef logic [PtrWidth-1:0] ptr_t;

  logic [PayloadWidth-1:0] payload_mem [TotCapacity];
  ptr_t                    next_mem    [TotCapacity];
  ptr_t                    head_q      [NumIds];
  ptr_t                    tail_q      [NumIds];
  logic [NumIds-1:0]       nonempty_q;

  logic [IDWidth-1:0]      in_id;
  logic [PayloadWidth-1:0] in_payload;
  logic                    push;
  logic [NumIds-1:0]       pop_vec;
  logic                    pop_any;
  ptr_t                    release_ptr;
  ptr_t                    alloc_ptr;
  logic                    free_any;

  assign in_id      = bus.in_data_i[IDWidth-1:0];
  assign in_payload = bus.in_data_i[StructWidth-1:IDWidth];
  assign push       = bus.in_valid_i & free_any;
  assign pop_vec    = bus.release_onehot_i & nonempty_q;
  assign pop_any    = |pop_vec;

  // release_onehot_i is one-hot, so OR-ing the selected heads picks the popped slot.
  always_comb begin
    release_ptr = '0;
    for (int i = 0; i < NumIds; i++) begin
      if (pop_vec[i]) release_ptr = release_ptr | head_q[i];
    end
  end

  simmem_freelist #(.TotCapacity(TotCapacity)) u_freelist (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (push),
    .alloc_ptr_o   (alloc_ptr),
    .free_any_o    (free_any),
    .release_i     (pop_any),
    .release_ptr_i (release_ptr)
  );

  always_ff @(posedge clk_i) begin
    if (push) begin
      payload_mem[alloc_ptr] <= in_payload;
      if (nonempty_q[in_id]) next_mem[tail_q[in_id]] <= alloc_ptr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nonempty_q <= '0;
      for (int i = 0; i < NumIds; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        if (pop_vec[i]) begin
          // head == tail means a single entry; its next pointer is not valid yet.
          if (head_q[i] == tail_q[i]) begin
            if (push && in_id == IDWidth'(i)) head_q[i] <= alloc_ptr;
            else                              nonempty_q[i] <= 1'b0;
          end else begin
            head_q[i] <= next_mem[head_q[i]];
          end
        end
        if (push && in_id == IDWidth'(i)) begin
          tail_q[i] <= alloc_ptr;
          if (!nonempty_q[i]) begin
            head_q[i]     <= alloc_ptr;
            nonempty_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.buf_data_valid_o = nonempty_q;
    for (int i = 0; i < NumIds; i++) begin
      bus.buf_data_o[i] = nonempty_q[i] ? payload_mem[head_q[i]] : '0;
    end
  end

  assign bus.in_ready_o = free_any;

`ifdef SIMMEM_STORE_OCCUPANCY_EN
  localparam int OccWidth = $clog2(TotCapacity + 1);
  logic [OccWidth-1:0] occupancy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupancy_q <= '0;
    end else if (push && !pop_any) begin
      occupancy_q <= occupancy_q + OccWidth'(1);
    end else if (!push && pop_any) begin
      occupancy_q <= occupancy_q - OccWidth'(1);
    end
  end

  assign occupancy_o = occupancy_q;
`endif

endmodule

// File: tb/tb_simmem_message_linkedlist_store.sv
// Bench for the linked-list message store: per-ID expected queues filled on push,
// popped and compared against the head output when the DUT releases a message.
module tb_simmem_message_linkedlist_store;

  localparam int NumIds = 16;
  localparam int PW     = 60;
  localparam int Cap    = 16;

  logic clk;
  logic rst;

  simmem_message_linkedlist_store_if #(.StructWidth(64), .IDWidth(4)) bus ();

`ifdef SIMMEM_STORE_OCCUPANCY_EN
  logic [4:0] occ;
`endif

  simmem_message_linkedlist_store #(
    .StructWidth (64),
    .IDWidth     (4),
    .TotCapacity (Cap)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef SIMMEM_STORE_OCCUPANCY_EN
    ,
    .occupancy_o (occ)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q [NumIds][$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int total();
    int s = 0;
    for (int i = 0; i < NumIds; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic check_state();
    logic [PW-1:0] head;
    check("in_ready", 64'(bus.in_ready_o), 64'(total() < Cap));
    for (int i = 0; i < NumIds; i++) begin
      head = '0;
      if (exp_q[i].size() > 0) head = exp_q[i][0];
      check($sformatf("head_valid[%0d]", i), 64'(bus.buf_data_valid_o[i]), 64'(exp_q[i].size() > 0));
      check($sformatf("head_data[%0d]", i), 64'(bus.buf_data_o[i]), 64'(head));
    end
`ifdef SIMMEM_STORE_OCCUPANCY_EN
    check("occupancy", 64'(occ), 64'(total()));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; applies inputs for one edge and updates the model.
  task automatic cycle(input logic v, input logic [3:0] id, input logic [PW-1:0] pl,
                       input logic [15:0] rel);
    logic          push_ok;
    logic [PW-1:0] popped;
    bus.in_valid_i       = v;
    bus.in_data_i        = {pl, id};
    bus.release_onehot_i = rel;
    push_ok = v && (total() < Cap);
    for (int i = 0; i < NumIds; i++) begin
      if (rel[i] && exp_q[i].size() > 0) begin
        popped = exp_q[i].pop_front();
        check($sformatf("pop_data[%0d]", i), 64'(bus.buf_data_o[i]), 64'(popped));
      end
    end
    if (push_ok) exp_q[id].push_back(pl);
    @(posedge clk);
    #1;
    bus.in_valid_i       = 1'b0;
    bus.release_onehot_i = '0;
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < NumIds; i++) begin
      while (exp_q[i].size() > 0) cycle(1'b0, 4'd0, '0, 16'(1) << i);
    end
  endtask

  function automatic logic [PW-1:0] rand_pl();
    return PW'({$urandom(), $urandom()});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  id;
    logic [15:0] rel;
    rst = 1'b1;
    bus.in_valid_i       = 1'b0;
    bus.in_data_i        = '0;
    bus.release_onehot_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.buf_data_valid_o), 64'h0);
    check("rst_data_or", 64'(|bus.buf_data_o), 64'h0);
    check("rst_ready", 64'(bus.in_ready_o), 64'h1);
    rst = 1'b0;
    check_state();

    // Two messages on ID 3, one on ID 5.
    cycle(1'b1, 4'd3, 60'hA, 16'h0);
    cycle(1'b1, 4'd3, 60'hB, 16'h0);
    cycle(1'b1, 4'd5, 60'hC, 16'h0);
    check("basic_valid", 64'(bus.buf_data_valid_o), 64'h0028);
    check("basic_head3", 64'(bus.buf_data_o[3]), 64'hA);
    check("basic_head5", 64'(bus.buf_data_o[5]), 64'hC);
    cycle(1'b0, 4'd0, '0, 16'h0008);
    check("rel_head3", 64'(bus.buf_data_o[3]), 64'hB);
    cycle(1'b0, 4'd0, '0, 16'h0008);
    check("rel_valid3", 64'(bus.buf_data_valid_o[3]), 64'h0);
    drain();

    // Same-ID push and pop with a single stored message.
    cycle(1'b1, 4'd7, 60'h11, 16'h0);
    cycle(1'b1, 4'd7, 60'h55, 16'h0080);
    check("pushpop_valid7", 64'(bus.buf_data_valid_o[7]), 64'h1);
    check("pushpop_head7", 64'(bus.buf_data_o[7]), 64'h55);
    // Push to ID 2 while popping ID 7.
    cycle(1'b1, 4'd2, 60'h22, 16'h0080);
    check("cross_valid", 64'(bus.buf_data_valid_o), 64'h0004);

    // Release of an empty list is ignored.
    cycle(1'b0, 4'd0, '0, 16'h0002);
    check("empty_rel_valid", 64'(bus.buf_data_valid_o), 64'h0004);
    drain();

    // Fill all slots, then pop with valid held: the push waits one cycle.
    for (int k = 0; k < Cap; k++) cycle(1'b1, 4'($urandom_range(0, 15)), rand_pl(), 16'h0);
    check("full_ready", 64'(bus.in_ready_o), 64'h0);
    id = 4'd0;
    for (int i = NumIds - 1; i >= 0; i--) if (exp_q[i].size() > 0) id = 4'(i);
    cycle(1'b1, 4'd9, 60'h99, 16'(1) << id);
    check("after_pop_ready", 64'(bus.in_ready_o), 64'h1);
    cycle(1'b1, 4'd9, 60'h99, 16'h0);
    check("refill_ready", 64'(bus.in_ready_o), 64'h0);
    drain();

    // Random traffic concentrated on a few IDs to build deep lists.
    for (int k = 0; k < 400; k++) begin
      rel = '0;
      if ($urandom_range(0, 2) != 0) rel = 16'(1) << $urandom_range(0, 3);
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), rand_pl(), rel);
    end
    drain();

    // Asynchronous reset with 10 messages stored.
    for (int k = 0; k < 10; k++) cycle(1'b1, 4'($urandom_range(0, 15)), rand_pl(), 16'h0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.buf_data_valid_o), 64'h0);
    check("async_rst_ready", 64'(bus.in_ready_o), 64'h1);
    for (int i = 0; i < NumIds; i++) exp_q[i].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();
    cycle(1'b1, 4'd1, 60'h123, 16'h0);
    check("post_rst_head1", 64'(bus.buf_data_o[1]), 64'h123);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
